phrase_player: RTL and testbench
================================

Name: phrase_player

Overview:
- Reader/sequencer for the phrase database ROM. Accepts a phrase address over a valid/ready handshake, drives the ROM address, and captures the returned entry: eight 4-bit note codes, eight length bits and the note count.
- Replays the notes in order with tempo-accurate durations, and presents the current note code to the tone generator.
- Sits between the song-order logic (upstream) and the tone generator (downstream).

Parameters:
- TICKS_PER_8TH, 1000: clock cycles per eighth note. Legal range is 1..2^(CNT_W-1)-1.
- CNT_W, 16: width of the duration counter. A quarter note (2*TICKS_PER_8TH) must fit.
- REST_CODE, 4'hD: note code meaning rest.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- phrase_addr  in  4  phrase to play
- phrase_valid  in  1  phrase_addr is valid
- phrase_ready  out  1  player accepts a phrase this cycle
- abort  in  1  stop playback immediately
- db_addr  out  4  address to phrase database
- db_entry  in  32  note codes; note i = db_entry[31-4i -: 4]
- length_entry  in  8  bit 7-i: 1 = quarter note, 0 = eighth note for note i
- n_note  in  3  number of notes minus 1
- note_code  out  4  current note code
- note_valid  out  1  a note slot is being played
- note_on  out  1  note_valid and note_code != REST_CODE
- note_strobe  out  1  one-cycle pulse on the first cycle of each note
- note_idx  out  3  index of the current note
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after a phrase completes normally

Behaviour:
- Reset: state IDLE. db_addr=0, note_code=0, note_idx=0, duration counter=0. note_valid, note_on, note_strobe, done and busy are all 0. Reset mid-playback abandons the phrase with no done pulse.
- All outputs are registered except two:
  - phrase_ready = (state==IDLE) && !abort.
  - note_on is derived combinationally from registered note_valid and note_code.
- The ROM is combinational; db_addr is registered and held stable until the next accept.
- IDLE:
  - Handshake completes when phrase_valid && phrase_ready. At that edge: db_addr <= phrase_addr, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - Capture db_entry, length_entry and n_note into internal registers.
  - idx <= 0; counter <= duration of note 0. Go to PLAY.
  - Later ROM input changes have no effect until the next LOAD.
- PLAY:
  - note_valid=1; note_code = captured nibble[idx]; note_idx = idx.
  - note_strobe=1 on the first cycle of each note.
  - Duration of note i = TICKS_PER_8TH × (length bit ? 2 : 1) cycles.
  - Counter decrements every cycle. On the last cycle of a note (counter==1):
    - if idx == captured n_note: go to IDLE, and done=1 in the first IDLE cycle;
    - else idx++, reload the counter, and strobe the next note.
  - Notes beyond n_note are never played. The total phrase duration is the sum of its note durations.
- Latency: handshake at cycle 0 → LOAD at cycle 1 → first note_strobe at cycle 2.
- Back-to-back phrases: a new phrase can be accepted in the same IDLE cycle that done is high. Minimum gap between phrases is 2 cycles with note_valid=0.
- abort:
  - In LOAD or PLAY: go to IDLE next edge. note_valid and note_strobe clear, no done pulse, idx is cleared.
  - In IDLE: blocks the handshake for that cycle.
  - Abort on the final cycle of the final note suppresses done.
- TICKS_PER_8TH=1: eighth notes last 1 cycle, so note_strobe can be high on consecutive cycles.
- busy=1 in LOAD and PLAY only.

Test Plan:
- TICKS_PER_8TH=2, play phrase 2 (entry 050C8A00, length 11000000, n_note 5) accepted at cycle 0 → db_addr=2 from cycle 1; codes 0,5,0,C,8,A lasting 4,4,2,2,2,2 cycles (cycles 2–17); strobes at cycles 2,6,10,12,14,16; done=1 at cycle 18; note_on=1 throughout.
- TICKS_PER_8TH=2, phrase 5 (A8C00000, 11110000, n_note 3) → codes A,8,C,0 at 4 cycles each; no fifth note is ever output; done at cycle 18.
- Unmapped address 0 (DDDDDDDD, 00000000, n_note 7) → 8 eighth notes of code D, 2 cycles each; note_valid=1 but note_on=0 throughout; done at cycle 18.
- phrase_valid held high with phrase 1 then phrase 3 → the second accept occurs in the cycle done=1; first strobe of phrase 3 follows 2 cycles later; the ROM input changing during PLAY does not alter playback.
- abort asserted during note 2 of phrase 1 → next cycle state IDLE, note_valid=0, no done pulse; abort raised together with phrase_valid in IDLE → no accept.
- rst asserted mid-PLAY → next cycle all outputs at reset values, with phrase_ready=1 once rst is deasserted.

Source files
------------

// File: rtl/phrase_player.sv
// Phrase database reader and note sequencer. Fetches one ROM entry per
// accepted phrase and replays its notes with tempo-accurate durations.
module phrase_player #(
  parameter int          TICKS_PER_8TH = 1000,
  parameter int          CNT_W         = 16,
  parameter logic [3:0]  REST_CODE     = 4'hD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  phrase_addr,
  input  logic        phrase_valid,
  output logic        phrase_ready,
  input  logic        abort,
  output logic [3:0]  db_addr,
  input  logic [31:0] db_entry,
  input  logic [7:0]  length_entry,
  input  logic [2:0]  n_note,
  output logic [3:0]  note_code,
  output logic        note_valid,
  output logic        note_on,
  output logic        note_strobe,
  output logic [2:0]  note_idx,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  localparam logic [CNT_W-1:0] DUR_8TH = CNT_W'(TICKS_PER_8TH);
  localparam logic [CNT_W-1:0] DUR_4TH = CNT_W'(2 * TICKS_PER_8TH);

  state_t           state_q, state_d;
  logic [3:0]       db_addr_q, db_addr_d;
  logic [31:0]      entry_q, entry_d;
  logic [7:0]       len_q, len_d;
  logic [2:0]       nn_q, nn_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [2:0]       nxt_idx;

  function automatic logic [3:0] nib(input logic [31:0] e, input logic [2:0] i);
    logic [31:0] s;
    s = e << {i, 2'b00};
    return s[31:28];
  endfunction

  function automatic logic [CNT_W-1:0] dur(input logic quarter);
    return quarter ? DUR_4TH : DUR_8TH;
  endfunction

  assign phrase_ready = (state_q == IDLE) && !abort;
  assign note_on      = valid_q && (code_q != REST_CODE);
  assign db_addr      = db_addr_q;
  assign note_code    = code_q;
  assign note_valid   = valid_q;
  assign note_strobe  = strobe_q;
  assign note_idx     = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;

  always_comb begin
    state_d   = state_q;
    db_addr_d = db_addr_q;
    entry_d   = entry_q;
    len_d     = len_q;
    nn_d      = nn_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    nxt_idx   = idx_q + 3'd1;
    case (state_q)
      IDLE: begin
        if (phrase_valid && phrase_ready) begin
          db_addr_d = phrase_addr;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = 3'd0;
          cnt_d   = '0;
          valid_d = 1'b0;
        end else begin
          // The first note is presented straight from the ROM so it appears
          // in the very first PLAY cycle.
          entry_d  = db_entry;
          len_d    = length_entry;
          nn_d     = n_note;
          idx_d    = 3'd0;
          cnt_d    = dur(length_entry[7]);
          code_d   = db_entry[31:28];
          valid_d  = 1'b1;
          strobe_d = 1'b1;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = 3'd0;
          cnt_d   = '0;
          valid_d = 1'b0;
        end else if (cnt_q == CNT_W'(1)) begin
          if (idx_q == nn_q) begin
            state_d = IDLE;
            idx_d   = 3'd0;
            cnt_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d    = nxt_idx;
            cnt_d    = dur(len_q[3'd7 - nxt_idx]);
            code_d   = nib(entry_q, nxt_idx);
            strobe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      db_addr_q <= 4'd0;
      entry_q   <= 32'd0;
      len_q     <= 8'd0;
      nn_q      <= 3'd0;
      idx_q     <= 3'd0;
      cnt_q     <= '0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_addr_q <= db_addr_d;
      entry_q   <= entry_d;
      len_q     <= len_d;
      nn_q      <= nn_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end
endmodule

// File: tb/tb_phrase_player.sv
// Bench for phrase_player: a per-cycle schedule model built from ROM contents,
// random and directed stimulus, plus literal timing pins from known phrases.
module tb_phrase_player;
  localparam int T = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  phrase_addr = 4'd0;
  logic        phrase_valid = 1'b0;
  logic        phrase_ready;
  logic        abort = 1'b0;
  logic [3:0]  db_addr;
  logic [31:0] db_entry = 32'd0;
  logic [7:0]  length_entry = 8'd0;
  logic [2:0]  n_note = 3'd0;
  logic [3:0]  note_code;
  logic        note_valid, note_on, note_strobe, busy, done;
  logic [2:0]  note_idx;

  phrase_player #(.TICKS_PER_8TH(T), .CNT_W(16), .REST_CODE(4'hD)) dut (
    .clk(clk), .rst(rst), .phrase_addr(phrase_addr), .phrase_valid(phrase_valid),
    .phrase_ready(phrase_ready), .abort(abort), .db_addr(db_addr),
    .db_entry(db_entry), .length_entry(length_entry), .n_note(n_note),
    .note_code(note_code), .note_valid(note_valid), .note_on(note_on),
    .note_strobe(note_strobe), .note_idx(note_idx), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {
    bit       busy, valid, strobe, done;
    bit [3:0] code;
    bit [2:0] idx;
  } exp_t;

  logic [31:0] rom_e [16];
  logic [7:0]  rom_l [16];
  logic [2:0]  rom_n [16];

  exp_t     cur;
  exp_t     fut[$];
  bit [3:0] exp_db;
  int       cyc = 0;
  int       total = 0, bad = 0;
  bit       en = 1'b0;
  int       acc_log[$], strobe_log[$], done_log[$];
  int       on_cnt = 0;

  function automatic exp_t idle_e(bit d);
    exp_t e;
    e.busy = 0; e.valid = 0; e.strobe = 0; e.done = d; e.code = 0; e.idx = 0;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expand the whole phrase into one expectation per cycle.
  task automatic build(input bit [3:0] a);
    exp_t e;
    e = idle_e(0); e.busy = 1;
    fut.push_back(e);
    for (int i = 0; i <= int'(rom_n[a]); i++) begin
      int d;
      d = rom_l[a][7-i] ? 2*T : T;
      for (int c = 0; c < d; c++) begin
        e.busy = 1; e.valid = 1; e.done = 0;
        e.strobe = (c == 0);
        e.code = rom_e[a][31-4*i -: 4];
        e.idx = 3'(i);
        fut.push_back(e);
      end
    end
    fut.push_back(idle_e(1));
  endtask

  // Model step plus accept logging.
  always @(posedge clk) begin
    if (phrase_valid && phrase_ready) acc_log.push_back(cyc);
    cyc++;
    if (rst) begin
      fut.delete(); cur = idle_e(0); exp_db = 0;
    end else if (cur.busy && abort) begin
      fut.delete(); cur = idle_e(0);
    end else if (!cur.busy && phrase_valid && !abort) begin
      fut.delete();
      exp_db = phrase_addr;
      build(phrase_addr);
      cur = fut.pop_front();
    end else if (fut.size() > 0) begin
      cur = fut.pop_front();
    end else begin
      cur = idle_e(0);
    end
  end

  // ROM returns real data only in the predicted LOAD cycle; garbage otherwise.
  always @(negedge clk) begin
    #1;
    if (cur.busy && !cur.valid) begin
      db_entry = rom_e[exp_db]; length_entry = rom_l[exp_db]; n_note = rom_n[exp_db];
    end else begin
      db_entry = $urandom; length_entry = 8'($urandom); n_note = 3'($urandom);
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("phrase_ready", phrase_ready, int'(!cur.busy && !abort));
      chk("busy", busy, cur.busy);
      chk("note_valid", note_valid, cur.valid);
      chk("note_strobe", note_strobe, cur.strobe);
      chk("done", done, cur.done);
      chk("note_idx", note_idx, cur.idx);
      chk("db_addr", db_addr, exp_db);
      chk("note_on", note_on, int'(cur.valid && cur.code != 4'hD));
      if (cur.valid) chk("note_code", note_code, cur.code);
      if (note_strobe) strobe_log.push_back(cyc);
      if (done) done_log.push_back(cyc);
      if (note_on) on_cnt++;
    end
  end

  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic clear_logs();
    acc_log.delete(); strobe_log.delete(); done_log.delete(); on_cnt = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cur.busy && n < 200) begin step(); n++; end
    if (n >= 200) chk("wait_idle timeout", 1, 0);
  endtask

  task automatic send(input bit [3:0] a);
    wait_idle();
    abort = 0; phrase_valid = 1; phrase_addr = a;
    step();
    phrase_valid = 0;
  endtask

  task automatic pin_phrase(input string nm, input bit [3:0] a, input int ns, input int exp_on);
    int acc;
    clear_logs();
    send(a);
    wait_idle(); step(); step();
    chk({nm, " accepts"}, acc_log.size(), 1);
    acc = (acc_log.size() > 0) ? acc_log[0] : 0;
    chk({nm, " strobes"}, strobe_log.size(), ns);
    chk({nm, " done count"}, done_log.size(), 1);
    if (done_log.size() > 0) chk({nm, " done cycle"}, done_log[0] - acc, 18);
    if (strobe_log.size() > 0) chk({nm, " first strobe"}, strobe_log[0] - acc, 2);
    chk({nm, " note_on cycles"}, on_cnt, exp_on);
  endtask

  initial begin
    int exp_s[6];
    int n;
    for (int i = 0; i < 16; i++) begin
      rom_e[i] = $urandom; rom_l[i] = 8'($urandom); rom_n[i] = 3'($urandom);
    end
    rom_e[0] = 32'hDDDDDDDD; rom_l[0] = 8'h00; rom_n[0] = 3'd7;
    rom_e[2] = 32'h050C8A00; rom_l[2] = 8'hC0; rom_n[2] = 3'd5;
    rom_e[5] = 32'hA8C00000; rom_l[5] = 8'hF0; rom_n[5] = 3'd3;
    rom_e[1] = 32'h12345678; rom_l[1] = 8'h5A; rom_n[1] = 3'd4;
    rom_e[3] = 32'h9ABD0E1F; rom_l[3] = 8'h81; rom_n[3] = 3'd6;
    cur = idle_e(0); exp_db = 0;
    @(posedge clk); en = 1;
    repeat (2) step();
    chk("reset note_code", note_code, 0);
    chk("reset db_addr", db_addr, 0);
    rst = 0;
    step();
    chk("ready after reset", phrase_ready, 1);

    // Phrase 2: literal strobe schedule.
    clear_logs();
    send(2);
    wait_idle(); step(); step();
    exp_s = '{2, 6, 10, 12, 14, 16};
    chk("p2 strobes", strobe_log.size(), 6);
    if (acc_log.size() == 1 && strobe_log.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("p2 strobe cycle", strobe_log[i] - acc_log[0], exp_s[i]);
    end
    if (acc_log.size() == 1 && done_log.size() == 1) chk("p2 done cycle", done_log[0] - acc_log[0], 18);
    else chk("p2 accept/done count", acc_log.size() * 10 + done_log.size(), 11);

    pin_phrase("p5", 5, 4, 16);
    pin_phrase("p0", 0, 8, 0);

    // Back-to-back: second accept lands in the done cycle of the first.
    clear_logs();
    phrase_valid = 1; phrase_addr = 1;
    n = 0;
    while (acc_log.size() < 1 && n < 50) begin step(); n++; end
    phrase_addr = 3;
    while (acc_log.size() < 2 && n < 200) begin step(); n++; end
    phrase_valid = 0;
    wait_idle(); step(); step();
    chk("b2b accepts", acc_log.size(), 2);
    if (acc_log.size() == 2 && done_log.size() >= 1) begin
      chk("b2b accept in done cycle", acc_log[1], done_log[0]);
      chk("b2b next strobe gap", strobe_log[5] - acc_log[1], 2);
    end

    // Abort during note 2, then abort racing a request in IDLE.
    clear_logs();
    send(1);
    n = 0;
    while (!(cur.valid && cur.idx == 2) && n < 100) begin step(); n++; end
    abort = 1; step(); abort = 0;
    chk("abort idle", busy, 0);
    chk("abort note_idx", note_idx, 0);
    step(); step();
    chk("abort no done", done_log.size(), 0);
    abort = 1; phrase_valid = 1; phrase_addr = 4'd2;
    step();
    abort = 0; phrase_valid = 0;
    step();
    chk("abort blocks accept", acc_log.size(), 1);

    // Reset mid-play.
    send(2);
    repeat (5) step();
    rst = 1; step(); rst = 0;
    chk("rst busy", busy, 0);
    chk("rst note_valid", note_valid, 0);
    chk("rst db_addr", db_addr, 0);
    chk("rst ready", phrase_ready, 1);

    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      phrase_valid = ($urandom_range(0, 2) == 0);
      phrase_addr  = 4'($urandom);
      abort        = ($urandom_range(0, 59) == 0);
      rst          = ($urandom_range(0, 499) == 0);
      step();
    end
    phrase_valid = 0; abort = 0; rst = 0;
    wait_idle(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
